// File: rtl/rng_pkg.sv
// Shared types and helpers for the rand_num checker: FSM states, LFSR selectors,
// and the single-step model LFSR used to predict the recovered bit stream.
package rng_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} checker_state_t;

    localparam logic FIBO_SEL = 1'b0;
    localparam logic GALO_SEL = 1'b1;
    localparam int   BYTE_W   = 8;

    // One model step; returns {output bit, next state}. The output bit is the feedback.
    function automatic logic [BYTE_W:0] lfsr_step(input logic sel_i, input logic [BYTE_W-1:0] s);
        logic              fb;
        logic [BYTE_W-1:0] nxt;
        fb  = 1'b0;
        nxt = s;
        case (sel_i)
            FIBO_SEL: begin
                fb  = s[7] ^ s[4] ^ s[2];
                nxt = {s[6:0], fb};
            end
            GALO_SEL: begin
                fb  = s[7];
                nxt = {s[6], s[5] ^ fb, s[4] ^ fb, s[3] ^ fb, s[2:0], fb};
            end
            default: ;
        endcase
        return {fb, nxt};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES InvSubBytes for one byte: undoes the generator's S-box whitening.
module aes_inv_sbox
    import rng_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BYTE_W-1:0] byte_o
);

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/rand_num_checker.sv
// Loopback checker for the whitened random byte stream: recovers the LFSR byte, replays it
// serially MSB first and compares each bit with a local model LFSR seeded like the generator.
module rand_num_checker
    import rng_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              start,
    input  logic              sel,
    input  logic [BYTE_W-1:0] seed,
    input  logic [BYTE_W-1:0] rand_num,
    input  logic              valid,
    output logic              busy,
    output logic              ser_out,
    output logic              ser_valid,
    output logic [BYTE_W-1:0] recovered,
    output logic              done,
    output logic              match,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    checker_state_t    state_q, state_d;
    logic              valid_q, sel_q, mis_q, match_q, timeout_q;
    logic [BYTE_W-1:0] model_q, shreg_q, recovered_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        tmo_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;

    logic              rise, tmo_hit, last_bit, bit_mis, check_fail;
    logic [BYTE_W:0]   step;
    logic [BYTE_W-1:0] inv_byte;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    aes_inv_sbox u_inv_sbox (
        .byte_i (rand_num),
        .byte_o (inv_byte)
    );

    assign rise       = valid & ~valid_q;
    assign tmo_hit    = (tmo_cnt_q == TMO_LAST);
    assign last_bit   = (bit_cnt_q == 3'd7);
    assign step       = lfsr_step(sel_q, model_q);
    assign bit_mis    = shreg_q[BYTE_W-1] ^ step[BYTE_W];
    assign check_fail = mis_q | bit_mis;

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = WAIT;
            end
            WAIT: begin
                // A valid edge in the last WAIT cycle still wins over the timeout.
                if (rise)         state_d = SHIFT;
                else if (tmo_hit) state_d = DONE;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg_q[BYTE_W-1];
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result flags and err_cnt are written on entry to DONE so they are valid alongside done.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            sel_q       <= FIBO_SEL;
            mis_q       <= 1'b0;
            match_q     <= 1'b0;
            timeout_q   <= 1'b0;
            model_q     <= '0;
            shreg_q     <= '0;
            recovered_q <= '0;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q     <= sel;
                        model_q   <= seed;
                        tmo_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        mis_q     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (rise) begin
                        shreg_q     <= inv_byte;
                        recovered_q <= inv_byte;
                    end else if (tmo_hit) begin
                        match_q   <= 1'b0;
                        timeout_q <= 1'b1;
                        err_cnt_q <= sat_inc(err_cnt_q);
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                SHIFT: begin
                    shreg_q <= {shreg_q[BYTE_W-2:0], 1'b0};
                    model_q <= step[BYTE_W-1:0];
                    mis_q   <= check_fail;
                    if (last_bit) begin
                        match_q   <= ~check_fail;
                        timeout_q <= 1'b0;
                        if (check_fail) err_cnt_q <= sat_inc(err_cnt_q);
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign recovered = recovered_q;
    assign match     = match_q;
    assign timeout   = timeout_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rand_num_checker.sv
// Self-checking bench for rand_num_checker: spec vectors, randomized checks against a
// GF(2^8)-derived S-box model, timeout, mid-check reset and err_cnt saturation.
module tb_rand_num_checker;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 32;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_L, start, sel, valid;
    logic [7:0]       seed, rand_num;
    logic             busy, ser_out, ser_valid, done, match, timeout;
    logic [7:0]       recovered;
    logic [CNT_W-1:0] err_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_err  = 0;
    logic [7:0] last_rec = 8'h00;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    typedef struct {
        logic [7:0] seed;
        logic       sel;
        logic [7:0] rnum;
        logic [7:0] rec;
        logic       mat;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    rand_num_checker #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .sel       (sel),
        .seed      (seed),
        .rand_num  (rand_num),
        .valid     (valid),
        .busy      (busy),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .recovered (recovered),
        .done      (done),
        .match     (match),
        .timeout   (timeout),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward AES S-box: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] iv;
        iv = 8'h00;
        if (v != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(v, 8'(y)) == 8'h01) iv = 8'(y);
        return iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                  ^ {iv[3:0], iv[7:4]} ^ 8'h63;
    endfunction

    // The eight model bits, first bit in the MSB, as the generator would have produced them.
    function automatic logic [7:0] model_byte(input logic [7:0] sd, input logic sl);
        logic [7:0] s;
        logic [7:0] r;
        logic       fb;
        s = sd;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (!sl) begin
                fb = s[7] ^ s[4] ^ s[2];
                s  = {s[6:0], fb};
            end else begin
                fb = s[7];
                s  = {s[6], s[5] ^ fb, s[4] ^ fb, s[3] ^ fb, s[2:0], fb};
            end
            r = {r[6:0], fb};
        end
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " ser_out"}, 32'(ser_out), 0);
        chk({tag, " ser_valid"}, 32'(ser_valid), 0);
        chk({tag, " recovered"}, 32'(recovered), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " match"}, 32'(match), 0);
        chk({tag, " timeout"}, 32'(timeout), 0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 0);
    endtask

    // One full check with a fresh valid edge dly cycles after WAIT entry.
    // done is captured by the 10th rising edge after valid rises, i.e. the 9th falling edge.
    task automatic run_check(input string tag, input logic [7:0] sd, input logic sl,
                             input logic [7:0] rn, input int dly,
                             input logic [7:0] exp_rec, input logic exp_mat);
        logic [7:0] got_ser;
        int         nser;
        int         done_at;
        @(negedge clk);
        start = 1'b1; seed = sd; sel = sl;
        @(negedge clk);
        start = 1'b0; seed = $urandom; sel = $urandom_range(0, 1);
        chk({tag, " busy"}, 32'(busy), 1);
        repeat (dly) @(negedge clk);
        valid = 1'b1; rand_num = rn;
        got_ser = 8'h00; nser = 0; done_at = -1;
        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            @(negedge clk);
            if (ser_valid) begin
                got_ser = {got_ser[6:0], ser_out};
                nser++;
            end
            if (done) done_at = k;
        end
        if (!exp_mat && exp_err < ERR_MAX) exp_err++;
        chk({tag, " done latency"}, 32'(done_at), 9);
        chk({tag, " ser count"}, 32'(nser), 8);
        chk({tag, " ser bits"}, 32'(got_ser), 32'(exp_rec));
        chk({tag, " recovered"}, 32'(recovered), 32'(exp_rec));
        chk({tag, " match"}, 32'(match), 32'(exp_mat));
        chk({tag, " timeout"}, 32'(timeout), 0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
        last_rec = exp_rec;
        valid = 1'b0; rand_num = $urandom;
    endtask

    initial begin
        logic [7:0] sd, rn, mb;
        logic       sl;
        int         done_at;
        logic       saw_ser;

        reset_L = 1'b0; start = 1'b0; sel = 1'b0; valid = 1'b0;
        seed = 8'h00; rand_num = 8'h00;

        for (int x = 0; x < 256; x++) begin
            fwd_tab[x]          = sbox(8'(x));
            inv_tab[fwd_tab[x]] = 8'(x);
        end

        vecs[0] = '{seed: 8'h00, sel: 1'b0, rnum: 8'h63, rec: 8'h00, mat: 1'b1};
        vecs[1] = '{seed: 8'h01, sel: 1'b0, rnum: 8'hD8, rec: 8'h2D, mat: 1'b1};
        vecs[2] = '{seed: 8'h01, sel: 1'b1, rnum: 8'h7C, rec: 8'h01, mat: 1'b1};
        vecs[3] = '{seed: 8'h00, sel: 1'b0, rnum: 8'h00, rec: 8'h52, mat: 1'b0};

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_L = 1'b1;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].seed, vecs[i].sel, vecs[i].rnum,
                      5, vecs[i].rec, vecs[i].mat);

        // Valid already high before start: no edge, so WAIT lasts TIMEOUT cycles.
        @(negedge clk);
        valid = 1'b1; rand_num = 8'h63;
        repeat (2) @(negedge clk);
        start = 1'b1; seed = 8'h00; sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("tmo busy", 32'(busy), 1);
        done_at = -1; saw_ser = 1'b0;
        for (int j = 2; j <= 60 && done_at < 0; j++) begin
            @(negedge clk);
            if (ser_valid) saw_ser = 1'b1;
            if (done) done_at = j;
        end
        if (exp_err < ERR_MAX) exp_err++;
        chk("tmo done cycle", 32'(done_at), TIMEOUT + 1);
        chk("tmo no ser_valid", 32'(saw_ser), 0);
        chk("tmo timeout", 32'(timeout), 1);
        chk("tmo match", 32'(match), 0);
        chk("tmo err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("tmo recovered holds", 32'(recovered), 32'(last_rec));
        valid = 1'b0;

        for (int i = 0; i < 24; i++) begin
            sd = 8'($urandom);
            sl = 1'($urandom_range(0, 1));
            mb = model_byte(sd, sl);
            rn = ($urandom_range(0, 1) == 1) ? fwd_tab[mb] : 8'($urandom);
            run_check($sformatf("rnd%0d", i), sd, sl, rn, $urandom_range(0, 6),
                      inv_tab[rn], inv_tab[rn] == mb);
        end

        // Reset while replaying bit 3: everything drops at once and no done follows.
        @(negedge clk);
        start = 1'b1; seed = 8'h01; sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        valid = 1'b1; rand_num = 8'hD8;
        repeat (4) @(negedge clk);
        chk("pre-reset ser_valid", 32'(ser_valid), 1);
        reset_L = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        chk("midreset held done", 32'(done), 0);
        valid = 1'b0;
        reset_L = 1'b1;
        exp_err = 0;
        run_check("post-reset", 8'h01, 1'b0, 8'hD8, 3, 8'h2D, 1'b1);

        for (int i = 0; i < ERR_MAX + 1; i++)
            run_check($sformatf("sat%0d", i), 8'h00, 1'b0, 8'h00, 0, 8'h52, 1'b0);
        chk("err_cnt saturated", 32'(err_cnt), ERR_MAX);
        run_check("after sat", 8'h01, 1'b1, 8'h7C, 1, 8'h01, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
